// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8N1 UART transmitter among N_REQ byte producers.
// Define UART_ARB_TAG_EN to prefix every data frame with a {5'b11110, grant_id} tag frame.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned GUARD_CYC = 5000,
    parameter int unsigned START_TO  = 4
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     ack,
    output logic [7:0]           data_out,
    output logic                 en_data_out,
    input  logic                 tx_busy,
    output logic [2:0]           grant_id,
    output logic                 err_start
);

    localparam int unsigned     TO_W    = $clog2(START_TO + 1);
    localparam logic [N_REQ-1:0] ONE_HOT = N_REQ'(1);
    localparam logic [12:0]     GUARD_LD = 13'(GUARD_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_START,
        WAIT_DONE,
        GUARD
`ifdef UART_ARB_TAG_EN
        ,
        TAG_LAUNCH,
        TAG_WAIT
`endif
    } state_t;

`ifdef UART_ARB_TAG_EN
    typedef enum logic [1:0] {PH_START, PH_DONE, PH_GUARD} phase_t;
    phase_t     r_phase;
    logic [7:0] r_byte;
`endif

    state_t           r_state;
    logic [N_REQ-1:0] r_ack;
    logic [7:0]       r_data_out;
    logic             r_en;
    logic [2:0]       r_grant_id;
    logic             r_err;
    logic [12:0]      r_guard_cnt;
    logic [TO_W-1:0]  r_to_cnt;

    logic             w_any;
    logic [2:0]       w_next_id;
    logic [7:0]       w_next_byte;

    // First pending requester searching upward from the last grant, wrapping.
    always_comb begin
        w_any       = 1'b0;
        w_next_id   = r_grant_id;
        w_next_byte = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            int unsigned idx;
            idx = (32'(r_grant_id) + k) % N_REQ;
            if (!w_any && req[idx]) begin
                w_any       = 1'b1;
                w_next_id   = idx[2:0];
                w_next_byte = req_data[8*idx +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_state     <= IDLE;
            r_ack       <= '0;
            r_en        <= 1'b0;
            r_data_out  <= '0;
            r_grant_id  <= 3'(N_REQ - 1);
            r_err       <= 1'b0;
            r_guard_cnt <= '0;
            r_to_cnt    <= '0;
`ifdef UART_ARB_TAG_EN
            r_phase     <= PH_START;
            r_byte      <= '0;
`endif
        end else begin
            r_en  <= 1'b0;
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any && !tx_busy) begin
                        r_grant_id <= w_next_id;
`ifdef UART_ARB_TAG_EN
                        r_byte     <= w_next_byte;
                        r_data_out <= {5'b11110, w_next_id};
                        r_state    <= TAG_LAUNCH;
`else
                        r_data_out <= w_next_byte;
                        r_state    <= LAUNCH;
`endif
                    end
                end
                LAUNCH: begin
                    r_en     <= 1'b1;
                    r_ack    <= ONE_HOT << r_grant_id;
                    r_to_cnt <= '0;
                    r_state  <= WAIT_START;
                end
                WAIT_START: begin
                    // The launch cycle itself does not count towards the timeout.
                    if (tx_busy) begin
                        r_state <= WAIT_DONE;
                    end else if (r_to_cnt == TO_W'(START_TO)) begin
                        r_err       <= 1'b1;
                        r_guard_cnt <= GUARD_LD;
                        r_state     <= GUARD;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_guard_cnt <= GUARD_LD;
                        r_state     <= GUARD;
                    end
                end
                GUARD: begin
                    if (r_guard_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_guard_cnt <= r_guard_cnt - 13'd1;
                    end
                end
`ifdef UART_ARB_TAG_EN
                TAG_LAUNCH: begin
                    r_en     <= 1'b1;
                    r_to_cnt <= '0;
                    r_phase  <= PH_START;
                    r_state  <= TAG_WAIT;
                end
                TAG_WAIT: begin
                    case (r_phase)
                        PH_START: begin
                            // Tag timeout drops the data frame; the request stays pending.
                            if (tx_busy) begin
                                r_phase <= PH_DONE;
                            end else if (r_to_cnt == TO_W'(START_TO)) begin
                                r_err       <= 1'b1;
                                r_guard_cnt <= GUARD_LD;
                                r_state     <= GUARD;
                            end else begin
                                r_to_cnt <= r_to_cnt + TO_W'(1);
                            end
                        end
                        PH_DONE: begin
                            if (!tx_busy) begin
                                r_guard_cnt <= GUARD_LD;
                                r_phase     <= PH_GUARD;
                            end
                        end
                        default: begin
                            if (r_guard_cnt == '0) begin
                                r_data_out <= r_byte;
                                r_state    <= LAUNCH;
                            end else begin
                                r_guard_cnt <= r_guard_cnt - 13'd1;
                            end
                        end
                    endcase
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack         = r_ack;
    assign data_out    = r_data_out;
    assign en_data_out = r_en;
    assign grant_id    = r_grant_id;
    assign err_start   = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected frames, a monitor checks each launch.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned G     = 20;
    localparam int unsigned STO   = 4;
    localparam int unsigned FRAME = 30;
`ifdef UART_ARB_TAG_EN
    localparam int unsigned MIN_GAP = G + 1;
`else
    localparam int unsigned MIN_GAP = G + 2;
`endif

    logic           clk = 1'b0;
    logic           res;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   ack;
    logic [7:0]     data_out;
    logic           en_data_out;
    logic           tx_busy;
    logic [2:0]     grant_id;
    logic           err_start;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .GUARD_CYC(G), .START_TO(STO)) dut (
        .clk(clk), .res(res), .req(req), .req_data(req_data), .ack(ack),
        .data_out(data_out), .en_data_out(en_data_out), .tx_busy(tx_busy),
        .grant_id(grant_id), .err_start(err_start)
    );

    typedef struct packed {
        logic [7:0]   d;
        logic [N-1:0] a;
        logic [2:0]   g;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned en_count = 0;
    bit          stuck = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic [N-1:0] a, input logic [2:0] g);
        exp_t e;
        e.d = d; e.a = a; e.g = g;
        sb.push_back(e);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int unsigned n);
        res = 1'b1;
        tick(n);
        res = 1'b0;
    endtask

    task automatic wait_ack(input logic [N-1:0] mask, input string name);
        int unsigned t = 0;
        while ((ack & mask) == '0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'((ack & mask) != '0), 1);
    endtask

    task automatic wait_busy(input logic val, input string name);
        int unsigned t = 0;
        while (tx_busy !== val && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(tx_busy), 32'(val));
    endtask

    // UART model: busy rises the cycle after en and stays high for FRAME cycles.
    initial begin
        int unsigned cnt = 0;
        bit pend = 1'b0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (res) begin
                tx_busy = 1'b0; cnt = 0; pend = 1'b0;
            end else begin
                if (pend) begin
                    tx_busy = 1'b1; cnt = FRAME; pend = 1'b0;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) tx_busy = 1'b0;
                end
                if (en_data_out && !stuck) pend = 1'b1;
            end
        end
    end

    // Monitor: sampled 1 time unit after each rising edge.
    initial begin
        logic prev_en = 1'b0;
        logic prev_busy = 1'b0;
        int unsigned cyc = 0;
        int unsigned last_fall = 0;
        bit have_fall = 1'b0;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (prev_busy && !tx_busy) begin
                last_fall = cyc;
                have_fall = 1'b1;
            end
            if (res) have_fall = 1'b0;
            if (ack != '0) check("ack_with_en", 32'(en_data_out), 1);
            if (en_data_out) begin
                en_count++;
                check("en_single", 32'(prev_en), 0);
                check("en_not_busy", 32'(tx_busy), 0);
                if (have_fall) check("guard_gap", 32'((cyc - last_fall) >= MIN_GAP), 1);
                check("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("frame_data", 32'(data_out), 32'(e.d));
                    check("frame_ack", 32'(ack), 32'(e.a));
                    check("frame_gid", 32'(grant_id), 32'(e.g));
                end
            end
            prev_en = en_data_out;
            prev_busy = tx_busy;
        end
    end

    initial begin
        res = 1'b1;
        req = '0;
        req_data = '0;
        tick(3);
        check("rst_ack", 32'(ack), 0);
        check("rst_en", 32'(en_data_out), 0);
        check("rst_data", 32'(data_out), 0);
        check("rst_gid", 32'(grant_id), N - 1);
        check("rst_err", 32'(err_start), 0);
        res = 1'b0;
        tick(1);

`ifdef UART_ARB_TAG_EN
        req_data[31:24] = 8'h7E;
        expect_frame(8'hF3, 4'b0000, 3'd3);
        expect_frame(8'h7E, 4'b1000, 3'd3);
        req = 4'b1000;
        wait_ack(4'b1000, "tag_ack");
        req = '0;
        tick(FRAME + G + 20);
        check("tag_en_total", en_count, 2);
`else
        // Single request after reset.
        req_data[23:16] = 8'h53;
        expect_frame(8'h53, 4'b0100, 3'd2);
        req = 4'b0100;
        wait_ack(4'b0100, "t1_ack");
        req = '0;
        wait_busy(1'b1, "t1_busy_rise");
        wait_busy(1'b0, "t1_busy_fall");
        tick(G + 10);
        check("t1_data_hold", 32'(data_out), 8'h53);
        check("t1_gid_hold", 32'(grant_id), 2);

        // All requesters held: rotation 0,1,2,3,0.
        do_reset(2);
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        expect_frame(8'hA0, 4'b0001, 3'd0);
        expect_frame(8'hA1, 4'b0010, 3'd1);
        expect_frame(8'hA2, 4'b0100, 3'd2);
        expect_frame(8'hA3, 4'b1000, 3'd3);
        expect_frame(8'hA0, 4'b0001, 3'd0);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(4'b1111, "t2_ack");
            if (i == 4) req = '0;
            tick(1);
        end
        wait_busy(1'b1, "t2_busy_rise");
        wait_busy(1'b0, "t2_busy_fall");
        tick(G + 10);

        // Start timeout with busy stuck low.
        do_reset(2);
        stuck = 1'b1;
        req_data[7:0] = 8'h11;
        expect_frame(8'h11, 4'b0001, 3'd0);
        req = 4'b0001;
        begin
            int unsigned t = 0;
            while (!en_data_out && t < 500) begin
                @(negedge clk);
                t++;
            end
            check("t3_en_seen", 32'(en_data_out), 1);
        end
        req = '0;
        tick(4);
        check("t3_err_early", 32'(err_start), 0);
        tick(1);
        check("t3_err_set", 32'(err_start), 1);
        tick(G + 10);
        check("t3_err_sticky", 32'(err_start), 1);
        stuck = 1'b0;
        req_data[15:8] = 8'h22;
        expect_frame(8'h22, 4'b0010, 3'd1);
        req = 4'b0010;
        wait_ack(4'b0010, "t3_ack2");
        req = '0;
        wait_busy(1'b1, "t3_busy_rise");
        wait_busy(1'b0, "t3_busy_fall");
        tick(G + 10);
        check("t3_err_after", 32'(err_start), 1);
        do_reset(2);
        check("t3_err_cleared", 32'(err_start), 0);

        // Reset in WAIT_DONE.
        req_data[23:16] = 8'h33;
        expect_frame(8'h33, 4'b0100, 3'd2);
        req = 4'b0100;
        wait_ack(4'b0100, "t4_ack");
        req = '0;
        wait_busy(1'b1, "t4_busy_rise");
        tick(5);
        res = 1'b1;
        tick(1);
        check("t4_rst_ack", 32'(ack), 0);
        check("t4_rst_en", 32'(en_data_out), 0);
        check("t4_rst_data", 32'(data_out), 0);
        check("t4_rst_gid", 32'(grant_id), N - 1);
        check("t4_rst_err", 32'(err_start), 0);
        tick(1);
        res = 1'b0;
        req_data[7:0] = 8'h44;
        expect_frame(8'h44, 4'b0001, 3'd0);
        req = 4'b0011;
        wait_ack(4'b0001, "t4_ack2");
        req = '0;
        wait_busy(1'b1, "t4_busy_rise2");
        wait_busy(1'b0, "t4_busy_fall2");
        tick(G + 10);

        // Request pulse confined to GUARD is never served.
        req_data[7:0] = 8'h55;
        expect_frame(8'h55, 4'b0001, 3'd0);
        req = 4'b0001;
        wait_ack(4'b0001, "t5_ack");
        req = '0;
        wait_busy(1'b1, "t5_busy_rise");
        wait_busy(1'b0, "t5_busy_fall");
        tick(2);
        req = 4'b0010;
        tick(10);
        req = '0;
        tick(G + 20);
        check("t5_en_total", en_count, 11);
`endif
        check("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one 8N1 UART transmitter among N_REQ byte producers. Sits directly in front of the 24 MHz / 4800 baud UART transmitter: accepts byte requests, launches one frame at a time through the transmitter's enable/busy handshake, and enforces a stop-bit guard interval between frames. Optionally prefixes each byte with a channel tag.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- GUARD_CYC, 5000: idle cycles inserted after tx_busy falls. One bit time at 24 MHz / 4800 baud covers the stop bit.
- START_TO, 4: cycles to wait for tx_busy to rise after a launch before flagging an error.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  reset, synchronous, active-high.
- req  in  N_REQ  per-requester byte request. The requester holds it until its ack.
- req_data  in  8*N_REQ  byte for requester i on bits [8i+7:8i]. Held stable with req.
- ack  out  N_REQ  one-cycle pulse; the byte of requester i has been handed to the UART.
- data_out  out  8  byte presented to the UART data input.
- en_data_out  out  1  one-cycle launch strobe to the UART enable.
- tx_busy  in  1  UART busy flag: 1 while a frame is shifting.
- grant_id  out  3  index of the current or last granted requester.
- err_start  out  1  sticky flag: the UART failed to raise busy within START_TO cycles. Cleared only by res.

## Operation
States: IDLE, LAUNCH, WAIT_START, WAIT_DONE, GUARD. In TAG mode, TAG_LAUNCH and TAG_WAIT are added (see Configuration).
- Reset (res=1 at a clk edge) puts the outputs in these states: state=IDLE, ack=0, en_data_out=0, data_out=8'h00, grant_id=N_REQ-1, err_start=0, guard counter=0. Reset mid-frame abandons the frame immediately. No ack is issued for it.
- IDLE: if any req bit is 1, select the first set bit searching upward from grant_id+1, wrapping modulo N_REQ. Register grant_id, latch data_out from that requester's slice, then go to LAUNCH. If no req is set, stay in IDLE.
- LAUNCH, a single cycle: en_data_out=1 and ack[grant_id]=1. Go to WAIT_START and clear the timeout counter.
- WAIT_START: wait for tx_busy=1, then go to WAIT_DONE. If START_TO cycles elapse without busy, set err_start and go to GUARD. The ack was already issued, so the byte counts as consumed.
- WAIT_DONE: wait for tx_busy=0, then go to GUARD and load the counter with GUARD_CYC-1.
- GUARD: decrement the counter. At 0, go to IDLE. The counter is 13 bits; GUARD_CYC must be at most 8191 and at least 1.
- Round-robin fairness: with all requests asserted continuously, grants rotate 0,1,…,N_REQ-1,0. The first grant after reset goes to requester 0.
- req is ignored outside IDLE. A request that drops before its ack is never served, and no partial output is produced.
- data_out holds its value from latch until the next grant.
- If tx_busy is already 1 in IDLE, the block does not launch. It stays in IDLE until tx_busy=0.

## Timing
- req[i] sampled high in IDLE at edge t: grant_id and data_out update at t; en_data_out and ack[i] are high for the single cycle after edge t+1.
- en_data_out is never high for two consecutive cycles.
- At most one ack bit is high per cycle, and only coincident with en_data_out.
- tx_busy falling seen at edge t gives IDLE after edge t+GUARD_CYC. The earliest next en_data_out is then 2 cycles later.
- Minimum launch-to-launch spacing is frame time + GUARD_CYC + 3 cycles.

## Configuration
- Macro UART_ARB_TAG_EN.
- Defined: each grant sends two frames.
  - First frame: the tag byte {5'b11110, grant_id} in TAG_LAUNCH, with en_data_out=1 and no ack. Then TAG_WAIT, which performs the WAIT_START/WAIT_DONE/GUARD sequence.
  - Second frame: the data byte through LAUNCH, where ack is issued.
  - The data byte is latched at grant time, so the requester still holds req until ack.
  - A start timeout on the tag frame sets err_start, skips the data frame, and returns to IDLE via GUARD with no ack. The request remains pending.
- Undefined: single data frame per grant exactly as described above. The TAG states are not present.

## Test plan
- Reset then single request: res for 3 cycles; req=4'b0100 with byte 8'h53; UART model raises busy 1 cycle after en and holds it 45000 cycles. Required: one en pulse, data_out=8'h53, ack=4'b0100, grant_id=2, and no second en until 5000+ cycles after busy falls.
- All four requesters held continuously with bytes 8'hA0..8'hA3 → frames in order A0,A1,A2,A3,A0; acks rotate 0→1→2→3; no en overlaps busy or guard.
- Start timeout: busy stuck at 0 after en → err_start=1 on the 5th cycle after en; the block returns to IDLE after GUARD; err_start remains set until res.
- Reset mid-frame: assert res during WAIT_DONE → all outputs at reset values on the next cycle; no spurious ack; the next request grants requester 0.
- Request withdrawn in GUARD: req[1] pulses high for 10 cycles only during GUARD → never acked and no extra en.
- With UART_ARB_TAG_EN: req[3] with byte 8'h7E → frames 8'hF3 then 8'h7E; ack[3] pulses only with the second en.
